// File: rtl/branch_history_table.sv
// PC-indexed table of saturating direction counters with optional gshare
// indexing and branch/mispredict statistics. Prediction is combinational;
// training happens at the clock edge from resolved branches.
module branch_history_table #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned GHR_W  = 0,
    parameter int unsigned INIT   = 0,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int unsigned      ENTRIES  = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT);

    // Parameter sanity checks
    if (GHR_W > IDX_W) begin : g_chk_ghr
        $error("branch_history_table: GHR_W must not exceed IDX_W");
    end
    if ((INIT >> CTR_W) != 0) begin : g_chk_init
        $error("branch_history_table: INIT must fit in CTR_W bits");
    end
    if (CTR_W < 1) begin : g_chk_ctr
        $error("branch_history_table: CTR_W must be at least 1");
    end
    if (PC_W < IDX_W + 3) begin : g_chk_pc
        $error("branch_history_table: PC_W too narrow for IDX_W");
    end

    logic [CTR_W-1:0] ctr [ENTRIES];
    logic             armed;
    logic             upd_en;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] hist;
    logic [CTR_W-1:0] cur_ctr;
    logic [CTR_W-1:0] nxt_ctr;
    logic             unused_pc;

    // Word-aligned PC: low two bits and bits above the index are not used
    assign unused_pc = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};
    assign base      = pred_pc[IDX_W+1:2];

    // Training is suppressed on the first edge after reset release
    assign upd_en = upd_valid & armed;

    // Arm training one edge after reset deasserts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Global history: shifted in only at resolution, never speculatively
    if (GHR_W == 0) begin : g_bimodal
        assign hist = '0;
    end else if (GHR_W == 1) begin : g_ghr1
        logic ghr;
        // Single-bit history tracks the last resolved outcome
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ghr <= 1'b0;
            end else if (upd_en) begin
                ghr <= upd_taken;
            end
        end
        assign hist = IDX_W'(ghr);
    end else begin : g_ghrn
        logic [GHR_W-1:0] ghr;
        // Multi-bit history shifts the newest outcome into the LSB
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ghr <= '0;
            end else if (upd_en) begin
                ghr <= {ghr[GHR_W-2:0], upd_taken};
            end
        end
        assign hist = IDX_W'(ghr);
    end

    // Combinational lookup; same-cycle updates are not bypassed
    assign pred_idx   = base ^ hist;
    assign pred_taken = ctr[pred_idx][CTR_W-1];

    // Saturating increment/decrement of the counter being trained
    always_comb begin
        cur_ctr = ctr[upd_idx];
        nxt_ctr = cur_ctr;
        if (upd_taken) begin
            if (cur_ctr != CTR_MAX) begin
                nxt_ctr = cur_ctr + CTR_W'(1);
            end
        end else begin
            if (cur_ctr != '0) begin
                nxt_ctr = cur_ctr - CTR_W'(1);
            end
        end
    end

    // Counter table storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= nxt_ctr;
        end
    end

    // Saturating branch and mispredict statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (upd_en) begin
            if (~&branch_cnt) begin
                branch_cnt <= branch_cnt + STAT_W'(1);
            end
            if ((upd_pred != upd_taken) && (~&miss_cnt)) begin
                miss_cnt <= miss_cnt + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench: a bimodal instance (defaults) and a gshare instance
// (GHR_W=4, STAT_W=3) share stimulus and are compared every cycle against an
// array-based behavioural model, plus directed literal checks.
module tb_branch_history_table;

    logic        clk;
    logic        rst;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_pred;

    logic        pt_b, pt_g;
    logic [5:0]  pi_b, pi_g;
    logic [31:0] bc_b, mc_b;
    logic [2:0]  bc_g, mc_g;

    int checks   = 0;
    int failures = 0;
    bit run      = 0;

    // Behavioural model state
    int     m_b [64];
    int     m_g [64];
    int     ghr_m;
    longint bbr, bms, gbr, gms;
    bit     live;

    branch_history_table dut_b (
        .clk(clk), .rst(rst), .pred_pc(pred_pc),
        .pred_taken(pt_b), .pred_idx(pi_b),
        .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
        .branch_cnt(bc_b), .miss_cnt(mc_b)
    );

    branch_history_table #(.GHR_W(4), .STAT_W(3)) dut_g (
        .clk(clk), .rst(rst), .pred_pc(pred_pc),
        .pred_taken(pt_g), .pred_idx(pi_g),
        .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
        .branch_cnt(bc_g), .miss_cnt(mc_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_step(input int c, input bit taken);
        if (taken) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    // Model: reset clears everything; first edge after release trains nothing
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                m_b[i] <= 0;
                m_g[i] <= 0;
            end
            ghr_m <= 0;
            bbr <= 0; bms <= 0; gbr <= 0; gms <= 0;
            live <= 1'b0;
        end else if (!live) begin
            live <= 1'b1;
        end else if (upd_valid) begin
            m_b[upd_idx] <= sat_step(m_b[upd_idx], upd_taken);
            m_g[upd_idx] <= sat_step(m_g[upd_idx], upd_taken);
            ghr_m <= ((ghr_m * 2) + int'(upd_taken)) % 16;
            bbr <= (bbr < 64'hFFFF_FFFF) ? bbr + 1 : bbr;
            gbr <= (gbr < 7) ? gbr + 1 : gbr;
            if (upd_pred != upd_taken) begin
                bms <= (bms < 64'hFFFF_FFFF) ? bms + 1 : bms;
                gms <= (gms < 7) ? gms + 1 : gms;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int ib, ig;
        if (run) begin
            ib = int'((pred_pc / 4) % 64);
            ig = ib ^ ghr_m;
            chk("b_pred_idx",   64'(pi_b), 64'(ib));
            chk("b_pred_taken", 64'(pt_b), 64'(m_b[ib] >= 2));
            chk("b_branch_cnt", 64'(bc_b), 64'(bbr));
            chk("b_miss_cnt",   64'(mc_b), 64'(bms));
            chk("g_pred_idx",   64'(pi_g), 64'(ig));
            chk("g_pred_taken", 64'(pt_g), 64'(m_g[ig] >= 2));
            chk("g_branch_cnt", 64'(bc_g), 64'(gbr));
            chk("g_miss_cnt",   64'(mc_g), 64'(gms));
        end
    end

    task automatic do_upd(input int idx, input bit t, input bit p);
        @(negedge clk); #1;
        upd_valid = 1'b1;
        upd_idx   = 6'(idx);
        upd_taken = t;
        upd_pred  = p;
    endtask

    task automatic idle(input logic [31:0] pc);
        @(negedge clk); #1;
        upd_valid = 1'b0;
        pred_pc   = pc;
    endtask

    initial begin
        rst = 1'b1; pred_pc = 32'h100;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_pred = 1'b0;
        #2 rst = 1'b0;
        run = 1'b1;

        // Reset defaults
        @(negedge clk); #1;
        chk("rst_pred_taken", 64'(pt_b), 64'd0);
        chk("rst_pred_idx",   64'(pi_b), 64'd0);
        chk("rst_branch_cnt", 64'(bc_b), 64'd0);
        chk("rst_miss_cnt",   64'(mc_b), 64'd0);

        // Release with an update on the release edge: must be dropped
        @(negedge clk); #1;
        rst = 1'b1;
        upd_valid = 1'b1; upd_idx = 6'd5; upd_taken = 1'b1; upd_pred = 1'b0;
        idle(32'h14); #1;
        chk("drop_branch_cnt", 64'(bc_b), 64'd0);

        // Training idx 5
        do_upd(5, 1'b1, 1'b0);
        do_upd(5, 1'b1, 1'b0);
        idle(32'h14); #1;
        chk("train_taken", 64'(pt_b), 64'd1);
        chk("train_miss",  64'(mc_b), 64'd2);
        do_upd(5, 1'b1, 1'b0);
        do_upd(5, 1'b0, 1'b1);
        idle(32'h14); #1;
        chk("train_nt1", 64'(pt_b), 64'd1);
        do_upd(5, 1'b0, 1'b1);
        idle(32'h14); #1;
        chk("train_nt2", 64'(pt_b), 64'd0);

        // Saturation on idx 3
        for (int k = 0; k < 5; k++) do_upd(3, 1'b1, 1'b1);
        idle(32'hC); #1;
        chk("sat_taken", 64'(pt_b), 64'd1);
        do_upd(3, 1'b0, 1'b1);
        idle(32'hC); #1;
        chk("sat_nowrap", 64'(pt_b), 64'd1);

        // Same-cycle read/update collision on idx 5 (counter 01 -> 10)
        idle(32'h14);
        do_upd(5, 1'b1, 1'b0); #1;
        chk("coll_same", 64'(pt_b), 64'd0);
        idle(32'h14); #1;
        chk("coll_next", 64'(pt_b), 64'd1);

        // Gshare: history taken,taken,not,taken -> 4'b1101
        do_upd(20, 1'b1, 1'b1);
        do_upd(21, 1'b1, 1'b1);
        do_upd(22, 1'b0, 1'b0);
        do_upd(23, 1'b1, 1'b1);
        idle(32'h40); #1;
        chk("gshare_idx", 64'(pi_g), 64'h1D);
        chk("stat3_sat",  64'(bc_g), 64'd7);

        // Reset mid-run
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_gidx", 64'(pi_g), 64'h10);
        chk("mid_rst_bcnt", 64'(bc_b), 64'd0);
        idle(32'hC); #1;
        chk("mid_rst_pred", 64'(pt_b), 64'd0);
        rst = 1'b1;

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 499) == 0) rst = 1'b0;
            else rst = 1'b1;
            pred_pc   = $urandom;
            upd_valid = ($urandom_range(0, 3) != 0);
            upd_idx   = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7))
                                                    : 6'($urandom_range(0, 63));
            upd_taken = ($urandom_range(0, 9) < 7);
            upd_pred  = 1'($urandom);
        end
        @(negedge clk); #1;
        rst = 1'b1; upd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
